// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, arbiter state codes and tile address helper
package vga_pkg;
    localparam int H_TOTAL        = 800;
    localparam int V_TOTAL        = 525;
    localparam int H_VISIBLE_AREA = 640;
    localparam int V_VISIBLE_AREA = 480;
    localparam int TILE_SHIFT     = 4;
    localparam int TILE_W         = 1 << TILE_SHIFT;
    localparam int TILES_X        = H_VISIBLE_AREA >> TILE_SHIFT;
    localparam int ADDR_WIDTH     = 11;
    localparam int DATA_WIDTH     = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    function automatic logic [ADDR_WIDTH-1:0] tile_addr(input logic [9:0] row, input logic [9:0] col);
        logic [ADDR_WIDTH-1:0] acc;
        acc = ADDR_WIDTH'(col);
        for (int i = 0; i <= $clog2(TILES_X); i++)
            if (TILES_X[i])
                acc = acc + (ADDR_WIDTH'(row) << i);
        return acc;
    endfunction
endpackage

// File: rtl/vga_tile_fetch_addr.sv
// vga_tile_fetch_addr: decides whether the counter position is a fetch slot and which tile it reads
module vga_tile_fetch_addr
    import vga_pkg::*;
(
    input  logic [9:0]            h_counter,
    input  logic [9:0]            v_counter,
    output logic                  fetch_valid,
    output logic [ADDR_WIDTH-1:0] fetch_addr
);
    localparam int LAST_H    = H_TOTAL - TILE_W;
    localparam int COL_H_END = (TILES_X - 1) * TILE_W;

    logic [9:0] v_next;
    logic [9:0] row;
    logic [9:0] col;
    logic       in_row_slot;
    logic       next_line_slot;
    logic       wrap_slot;

    // Columns 1.. are fetched one tile ahead within the line; column 0 of the next line at the line end
    always_comb begin
        v_next         = v_counter + 10'd1;
        in_row_slot    = h_counter[TILE_SHIFT-1:0] == '0 && h_counter < 10'(COL_H_END) && v_counter < 10'(V_VISIBLE_AREA);
        next_line_slot = h_counter == 10'(LAST_H) && v_next < 10'(V_VISIBLE_AREA);
        wrap_slot      = h_counter == 10'(LAST_H) && v_counter == 10'(V_TOTAL - 1);
        row            = wrap_slot ? '0 : next_line_slot ? v_next >> TILE_SHIFT : v_counter >> TILE_SHIFT;
        col            = in_row_slot ? (h_counter >> TILE_SHIFT) + 10'd1 : '0;
        fetch_valid    = in_row_slot | next_line_slot | wrap_slot;
        fetch_addr     = tile_addr(row, col);
    end
endmodule

// File: rtl/vga_tile_ram_arbiter.sv
// vga_tile_ram_arbiter: shares the tile RAM between display prefetch and game-logic writes
module vga_tile_ram_arbiter
    import vga_pkg::*;
(
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [9:0]            i_H_Counter,
    input  logic [9:0]            i_V_Counter,
    input  logic                  i_Wr_Req,
    input  logic [ADDR_WIDTH-1:0] i_Wr_Addr,
    input  logic [DATA_WIDTH-1:0] i_Wr_Data,
    output logic                  o_Wr_Ack,
    output logic [ADDR_WIDTH-1:0] o_Ram_Addr,
    output logic                  o_Ram_We,
    output logic [DATA_WIDTH-1:0] o_Ram_WData,
    input  logic [DATA_WIDTH-1:0] i_Ram_RData,
    output logic [DATA_WIDTH-1:0] o_Tile_Data,
    output logic                  o_VBlank_Tick
);
    logic                  fetch_valid;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] fetch_buf;
    logic                  show_tile;

    vga_tile_fetch_addr u_fetch_addr (
        .h_counter   (i_H_Counter),
        .v_counter   (i_V_Counter),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr)
    );

    // Fetch always wins; a writer just acked sits out one cycle so it can present its next request
    always_comb state_next = fetch_valid ? ST_FETCH : (i_Wr_Req && !o_Wr_Ack) ? ST_WRITE : ST_IDLE;

    // Tile boundaries inside the visible area move the prefetched word to the pixel path
    always_comb show_tile = i_H_Counter[TILE_SHIFT-1:0] == '0 && i_H_Counter < 10'(H_VISIBLE_AREA) && i_V_Counter < 10'(V_VISIBLE_AREA);

    // RAM port registers; idle cycles keep the previous address and data
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state       <= ST_IDLE;
            o_Ram_Addr  <= '0;
            o_Ram_We    <= 1'b0;
            o_Ram_WData <= '0;
            o_Wr_Ack    <= 1'b0;
        end else begin
            state    <= state_next;
            o_Ram_We <= state_next == ST_WRITE;
            o_Wr_Ack <= state_next == ST_WRITE;
            if (state_next == ST_FETCH)
                o_Ram_Addr <= fetch_addr;
            else if (state_next == ST_WRITE) begin
                o_Ram_Addr  <= i_Wr_Addr;
                o_Ram_WData <= i_Wr_Data;
            end
        end
    end

    // Read pipeline: fetch address cycle, then RAM data cycle, then capture into the fetch buffer
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            rd_valid  <= 1'b0;
            fetch_buf <= '0;
        end else begin
            rd_valid <= state == ST_FETCH;
            if (rd_valid)
                fetch_buf <= i_Ram_RData;
        end
    end

    // Display register and start-of-vblank pulse, both one cycle behind the counters
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Tile_Data   <= '0;
            o_VBlank_Tick <= 1'b0;
        end else begin
            o_VBlank_Tick <= i_H_Counter == '0 && i_V_Counter == 10'(V_VISIBLE_AREA);
            if (show_tile)
                o_Tile_Data <= fetch_buf;
        end
    end
endmodule

// File: tb/tb_vga_tile_ram_arbiter.sv
// tb_vga_tile_ram_arbiter: randomized bench against a cycle-history reference model
module tb_vga_tile_ram_arbiter;
    localparam int HT = 800;
    localparam int VT = 525;
    localparam int HV = 640;
    localparam int VV = 480;
    localparam int TW = 16;
    localparam int TX = 40;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b0;
    logic [9:0]  i_H_Counter = '0;
    logic [9:0]  i_V_Counter = '0;
    logic        i_Wr_Req = 1'b0;
    logic [10:0] i_Wr_Addr = '0;
    logic [7:0]  i_Wr_Data = '0;
    logic        o_Wr_Ack;
    logic [10:0] o_Ram_Addr;
    logic        o_Ram_We;
    logic [7:0]  o_Ram_WData;
    logic [7:0]  i_Ram_RData = '0;
    logic [7:0]  o_Tile_Data;
    logic        o_VBlank_Tick;

    logic [7:0] mem [2048];
    logic [7:0] ref_mem [2048];

    int total = 0;
    int bad = 0;
    int idx = 0;
    int wr_mode = 0;
    bit counting = 0;
    int fetch_seen = 0;
    int blank_fetch = 0;
    int stolen = 0;
    int ticks = 0;

    bit         e_ack, e_we, e_tick;
    logic [10:0] e_addr;
    logic [7:0]  e_wd, e_tile;
    int          fq_idx[$];
    logic [7:0]  fq_val[$];

    vga_tile_ram_arbiter dut (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_H_Counter   (i_H_Counter),
        .i_V_Counter   (i_V_Counter),
        .i_Wr_Req      (i_Wr_Req),
        .i_Wr_Addr     (i_Wr_Addr),
        .i_Wr_Data     (i_Wr_Data),
        .o_Wr_Ack      (o_Wr_Ack),
        .o_Ram_Addr    (o_Ram_Addr),
        .o_Ram_We      (o_Ram_We),
        .o_Ram_WData   (o_Ram_WData),
        .i_Ram_RData   (i_Ram_RData),
        .o_Tile_Data   (o_Tile_Data),
        .o_VBlank_Tick (o_VBlank_Tick)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) begin
        if (o_Ram_We)
            mem[o_Ram_Addr] <= o_Ram_WData;
        i_Ram_RData <= mem[o_Ram_Addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit slot(input int h, input int v, output int a);
        a = 0;
        if (v < VV && h % TW == 0 && h / TW + 1 < TX) begin
            a = (v / TW) * TX + h / TW + 1;
            return 1;
        end
        if (h == HT - TW && v == VT - 1)
            return 1;
        if (h == HT - TW && v + 1 < VV) begin
            a = ((v + 1) / TW) * TX;
            return 1;
        end
        return 0;
    endfunction

    task automatic step(input int h, input int v, input bit r);
        int fa;
        bit f;
        logic [7:0] tv;
        i_H_Counter = 10'(h);
        i_V_Counter = 10'(v);
        i_Rst = r;
        f = 0;
        fa = 0;
        if (r) begin
            e_ack = 0;
            e_we = 0;
            e_addr = '0;
            e_wd = '0;
            e_tile = '0;
            e_tick = 0;
            fq_idx.delete();
            fq_val.delete();
        end else begin
            f = slot(h, v, fa);
            e_ack = !f && i_Wr_Req && !e_ack;
            e_we = e_ack;
            if (f) begin
                e_addr = 11'(fa);
                fq_idx.push_back(idx);
                fq_val.push_back(ref_mem[fa]);
                if (fq_idx.size() > 4) begin
                    void'(fq_idx.pop_front());
                    void'(fq_val.pop_front());
                end
            end
            if (e_we) begin
                e_addr = i_Wr_Addr;
                e_wd = i_Wr_Data;
                ref_mem[i_Wr_Addr] = i_Wr_Data;
            end
            e_tick = h == 0 && v == VV;
            if (h % TW == 0 && h < HV && v < VV) begin
                tv = '0;
                foreach (fq_idx[k])
                    if (fq_idx[k] <= idx - 3)
                        tv = fq_val[k];
                e_tile = tv;
            end
        end
        idx++;
        @(posedge i_Clk);
        #1;
        chk("we", o_Ram_We, e_we);
        chk("ack", o_Wr_Ack, e_ack);
        chk("tick", o_VBlank_Tick, e_tick);
        chk("tile", o_Tile_Data, e_tile);
        if (r || f || e_we)
            chk("addr", o_Ram_Addr, e_addr);
        if (r || e_we)
            chk("wdata", o_Ram_WData, e_wd);
        if (counting) begin
            if (f && !o_Ram_We && o_Ram_Addr == 11'(fa)) begin
                fetch_seen++;
                if (v >= VV)
                    blank_fetch++;
            end
            if (e_we && !o_Ram_We)
                stolen++;
            ticks += int'(o_VBlank_Tick);
        end
        if (wr_mode == 0) begin
            if (o_Wr_Ack)
                i_Wr_Req = 1'b0;
        end else if (o_Wr_Ack || !i_Wr_Req) begin
            i_Wr_Req = wr_mode == 2 || $urandom % 3 != 0;
            i_Wr_Addr = 11'($urandom);
            i_Wr_Data = 8'($urandom);
        end
    endtask

    initial begin
        bit got;
        int h;
        int v;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        i_Wr_Req = 1'b1;
        i_Wr_Addr = 11'h7F0;
        i_Wr_Data = 8'h11;
        repeat (3) begin
            step(700, 500, 1);
            chk("rst_ack", o_Wr_Ack, 0);
            chk("rst_we", o_Ram_We, 0);
            chk("rst_tile", o_Tile_Data, 0);
        end
        got = 0;
        for (int k = 0; k < 2 && !got; k++) begin
            step(700 + k + 1, 500, 0);
            got = o_Wr_Ack;
        end
        chk("rst_first_ack", got, 1);

        step(100, 500, 0);
        i_Wr_Req = 1'b1;
        i_Wr_Addr = 11'h123;
        i_Wr_Data = 8'h5A;
        step(101, 500, 0);
        chk("w_we", o_Ram_We, 1);
        chk("w_addr", o_Ram_Addr, 11'h123);
        chk("w_data", o_Ram_WData, 8'h5A);
        chk("w_ack", o_Wr_Ack, 1);

        step(30, 40, 0);
        step(31, 40, 0);
        i_Wr_Req = 1'b1;
        i_Wr_Addr = 11'h400;
        i_Wr_Data = 8'h3C;
        step(32, 40, 0);
        chk("c1_addr", o_Ram_Addr, 83);
        chk("c1_we", o_Ram_We, 0);
        chk("c1_ack", o_Wr_Ack, 0);
        step(33, 40, 0);
        chk("c2_we", o_Ram_We, 1);
        chk("c2_ack", o_Wr_Ack, 1);
        chk("c2_addr", o_Ram_Addr, 11'h400);

        mem[0] = 8'hAB;
        ref_mem[0] = 8'hAB;
        for (int x = 780; x < 800; x++) begin
            step(x, 524, 0);
            if (x == 784) begin
                chk("wrap_addr", o_Ram_Addr, 0);
                chk("wrap_we", o_Ram_We, 0);
            end
        end
        for (int x = 0; x < 4; x++) begin
            step(x, 0, 0);
            chk("wrap_tile", o_Tile_Data, 8'hAB);
        end

        mem[85] = 8'h77;
        ref_mem[85] = 8'h77;
        for (int x = 60; x <= 100; x++) begin
            step(x, 32, 0);
            if (x >= 80 && x <= 95)
                chk("t5_tile", o_Tile_Data, 8'h77);
        end

        step(799, 479, 0);
        step(0, 480, 0);
        chk("vb_tick", o_VBlank_Tick, 1);
        step(1, 480, 0);
        chk("vb_tick_end", o_VBlank_Tick, 0);

        i_Wr_Req = 1'b1;
        i_Wr_Addr = 11'h555;
        i_Wr_Data = 8'h99;
        step(10, 500, 0);
        i_Wr_Req = 1'b1;
        step(11, 500, 1);
        chk("midrst_ram", mem[11'h555], 8'h99);
        chk("midrst_ack", o_Wr_Ack, 0);
        step(12, 500, 0);
        chk("reserve_ack", o_Wr_Ack, 1);

        wr_mode = 1;
        for (int s = 0; s < 12; s++) begin
            v = $urandom_range(0, VT - 1);
            h = (s % 3 == 0) ? 770 : $urandom_range(0, HT - 1);
            for (int n = 0; n < 150; n++) begin
                step(h, v, $urandom % 80 == 0);
                h++;
                if (h == HT) begin
                    h = 0;
                    v = (v + 1) % VT;
                end
            end
        end

        wr_mode = 2;
        counting = 1;
        for (int y = 0; y < VT; y++)
            for (int x = 0; x < HT; x += TW)
                step(x, y, 0);
        counting = 0;
        chk("frame_fetches", fetch_seen, TX * VV);
        chk("frame_blank_fetch", blank_fetch, 1);
        chk("frame_stolen", stolen, 0);
        chk("frame_ticks", ticks, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
